// File: rtl/mem_port_sched_pkg.sv
// Shared sizes and scheduler state encodings for the data-memory port scheduler.
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif

package mem_port_sched_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/mem_port_sched.sv
// Dual-port data memory scheduler: alternates setup/access ports every cycle and
// hands free setup slots to a secondary valid/ready requester, with starvation relief.
module mem_port_sched
  import mem_port_sched_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic                  iw_pl_req,
  input  logic [`SIZE_ADDR-1:0] iw_pl_addr,
  input  logic                  iw_pl_we,
  input  logic [`SIZE_DATA-1:0] iw_pl_wdata,
  output logic                  ow_pl_stall,
  output logic                  ow_mem_mp,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr0,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr1,
  output logic                  ow_mem_we0,
  output logic                  ow_mem_we1,
  output logic [`SIZE_DATA-1:0] ow_mem_wdata0,
  output logic [`SIZE_DATA-1:0] ow_mem_wdata1,
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata0,
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata1,
  input  logic                  iw_dma_valid,
  input  logic                  iw_dma_we,
  input  logic [`SIZE_ADDR-1:0] iw_dma_addr,
  input  logic [`SIZE_DATA-1:0] iw_dma_wdata,
  output logic                  ow_dma_ready,
  output logic                  ow_dma_rvalid,
  output logic [`SIZE_DATA-1:0] ow_dma_rdata,
  output logic [1:0]            ow_dbg_state,
  output logic [CNT_W-1:0]      ow_dbg_wait
);

  // Secondary handshake: a request transfers in any cycle where iw_dma_valid and
  // ow_dma_ready are both high; valid may be held or dropped freely before that.

  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic                  r_mp;
  logic [`SIZE_ADDR-1:0] r_addr0;
  logic [`SIZE_ADDR-1:0] r_addr1;
  logic                  r_port;
  logic                  r_we;
  logic [`SIZE_DATA-1:0] r_wdata;
  logic [CNT_W-1:0]      r_wait;
  logic                  r_rvalid;
  logic [`SIZE_DATA-1:0] r_rdata;

  logic                  w_idle;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_pl_load;
  logic                  w_setup_port;
  logic                  w_starved;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_setup_port = ~r_mp;
  assign w_starved    = (r_wait == CNT_W'(STARVE_MAX));
  assign w_stall      = w_idle & iw_dma_valid & iw_pl_req & w_starved;
  // A forced stall hands the slot to the secondary even though MA is requesting.
  assign w_accept     = w_idle & iw_dma_valid & (w_stall | ~iw_pl_req);
  assign w_pl_load    = iw_pl_req & ~w_stall;

  assign ow_pl_stall   = w_stall;
  assign ow_dma_ready  = w_accept;
  assign ow_mem_mp     = r_mp;
  assign ow_mem_addr0  = r_addr0;
  assign ow_mem_addr1  = r_addr1;
  assign ow_dma_rvalid = r_rvalid;
  assign ow_dma_rdata  = r_rdata;
  assign ow_dbg_state  = r_state;
  assign ow_dbg_wait   = r_wait;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_ACC;
      ST_ACC:  w_state_nxt = r_we ? ST_IDLE : ST_RSP;
      ST_RSP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state  <= ST_IDLE;
      r_mp     <= 1'b0;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wait   <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mp     <= ~r_mp;
      r_rvalid <= (r_state == ST_RSP);
      if (r_state == ST_RSP) r_rdata <= r_port ? iw_mem_rdata1 : iw_mem_rdata0;
      if (w_accept) begin
        r_port  <= w_setup_port;
        r_we    <= iw_dma_we;
        r_wdata <= iw_dma_wdata;
        r_wait  <= '0;
      end else if (w_idle && iw_dma_valid && iw_pl_req && !w_starved) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  // Only the setup port may load; the access port keeps the address set up last cycle.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_addr0 <= '0;
      r_addr1 <= '0;
    end else if (w_accept) begin
      if (w_setup_port) r_addr1 <= iw_dma_addr;
      else              r_addr0 <= iw_dma_addr;
    end else if (w_pl_load) begin
      if (w_setup_port) r_addr1 <= iw_pl_addr;
      else              r_addr0 <= iw_pl_addr;
    end
  end

  always_comb begin
    ow_mem_we0    = 1'b0;
    ow_mem_we1    = 1'b0;
    ow_mem_wdata0 = '0;
    ow_mem_wdata1 = '0;
    if (r_state == ST_ACC) begin
      if (r_port) begin
        ow_mem_we1    = r_we;
        ow_mem_wdata1 = r_wdata;
      end else begin
        ow_mem_we0    = r_we;
        ow_mem_wdata0 = r_wdata;
      end
    end else if (r_mp) begin
      ow_mem_we1    = iw_pl_we;
      ow_mem_wdata1 = iw_pl_wdata;
    end else begin
      ow_mem_we0    = iw_pl_we;
      ow_mem_wdata0 = iw_pl_wdata;
    end
  end

  a_no_pl_we_in_acc: assert property (
    @(posedge iw_clk) disable iff (!iw_rst_n) (r_state == ST_ACC) |-> !iw_pl_we
  );

endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Memory-port scheduler for the dual-port data memory shared by the MA/MO pipeline stages and a secondary requester (debug/DMA). It owns the port-alternation bit, registers the per-port address so the address set up in one cycle is held for the access in the next, and gives a valid/ready requester the free setup slots. A starvation counter guarantees that the secondary requester is eventually served by stalling the pipeline for one slot.

## Interface

Parameters:

- STARVE_MAX, 8: number of blocked IDLE cycles before the pipeline is stalled for one slot; must be at least 1.
- CNT_W, 4: width of the wait counter; must hold STARVE_MAX.

Ports:

- iw_clk  in  1  clock.
- iw_rst_n  in  1  asynchronous, active-low reset.
- iw_pl_req  in  1  MA stage has a memory operation this cycle.
- iw_pl_addr  in  `SIZE_ADDR  MA address.
- iw_pl_we  in  1  MO write strobe for the current access cycle.
- iw_pl_wdata  in  `SIZE_DATA  MO write data.
- ow_pl_stall  out  1  MA request refused this cycle; MA must hold its request and retry.
- ow_mem_mp  out  1  access port index for the current cycle; the setup port is ~ow_mem_mp.
- ow_mem_addr0, ow_mem_addr1  out  `SIZE_ADDR  registered port addresses.
- ow_mem_we0, ow_mem_we1  out  1  port write enables.
- ow_mem_wdata0, ow_mem_wdata1  out  `SIZE_DATA  port write data.
- iw_mem_rdata0, iw_mem_rdata1  in  `SIZE_DATA  port read data, valid the cycle after the access.
- iw_dma_valid  in  1  secondary request valid.
- iw_dma_we  in  1  secondary request is a write.
- iw_dma_addr  in  `SIZE_ADDR  secondary address.
- iw_dma_wdata  in  `SIZE_DATA  secondary write data.
- ow_dma_ready  out  1  secondary request accepted this cycle.
- ow_dma_rvalid  out  1  one-cycle read-response strobe.
- ow_dma_rdata  out  `SIZE_DATA  read response data.

## Operation

- r_mp resets to 0 and toggles every cycle. ow_mem_mp = r_mp. Setup port s = ~r_mp.
- Address registers: in each cycle only addr[s] may load; addr[r_mp] holds its value.
- Setup-slot priority in cycle t:
  - If stall is forced, the secondary request wins.
  - Otherwise, if iw_pl_req, the pipeline wins and addr[s] <= iw_pl_addr.
  - Otherwise, if state is IDLE and iw_dma_valid, the secondary request wins.
- Secondary accept: ow_dma_ready=1 (combinational). On accept, addr[s] <= iw_dma_addr, and the block latches we, wdata and port s, then goes to ACC.
- ow_pl_stall = (state==IDLE) & iw_dma_valid & iw_pl_req & (r_wait==STARVE_MAX).
- FSM states are IDLE, ACC and RSP.
  - IDLE: on accept go to ACC.
  - ACC: the port equals the current r_mp. Drive ow_mem_we[port] = latched we and ow_mem_wdata[port] = latched wdata. A write returns to IDLE; a read goes to RSP.
  - RSP: capture iw_mem_rdata[port] into r_rdata, set r_rvalid for one cycle, and return to IDLE.
- Pipeline writes: in any cycle not in ACC, ow_mem_we[r_mp] = iw_pl_we and ow_mem_wdata[r_mp] = iw_pl_wdata. The enable for the other port is 0.
- In ACC the access port is owned by the secondary requester. iw_pl_we in that cycle is a protocol error; it is ignored and an assertion must fire in simulation.
- r_wait:
  - Cleared on accept.
  - Increments, saturating at STARVE_MAX, on each IDLE cycle with iw_dma_valid & iw_pl_req & ~ow_pl_stall.
  - Holds otherwise. It does not count in ACC or RSP.
- Reset values: r_mp=0, addr0/1=0, state=IDLE, r_wait=0, r_rvalid=0, r_rdata=0. All enables are 0, ow_dma_ready=0 and ow_pl_stall=0.
- Reset mid-operation aborts the transaction: no write is issued, no response is sent, and there is no retry.

## Timing

- Secondary accept in cycle t:
  - Memory access on port s at t+1.
  - Write: done at t+1; IDLE again at t+2, so the earliest next ready is t+2.
  - Read: data on iw_mem_rdata[s] at t+2, captured in RSP. ow_dma_rvalid and ow_dma_rdata are valid at t+3. IDLE again at t+3, so a new accept is allowed in the same cycle as rvalid.
- Pipeline setup at t: access on port s at t+1 with the held address.
- ow_dma_ready and ow_pl_stall are combinational from registered state and current inputs. All other outputs are registered, except the write enables and write data, which are muxes on registered state.
- Simultaneous iw_pl_req and iw_dma_valid below the threshold: the pipeline wins and r_wait increments.

## Structure

- Reuse `SIZE_ADDR and `SIZE_DATA from the shared sizes header.
- Add FSM state encodings (IDLE=2'd0, ACC=2'd1, RSP=2'd2) to a shared memsched header.
- No sub-module. An optional port_addr_reg primitive may be used for the two held address registers.

## Test plan

- Reset: hold iw_rst_n=0 for 3 cycles. All outputs are 0; after release ow_mem_mp toggles 0,1,0,...
- Pipeline only: iw_pl_req with addr 0x000123 at a cycle where mp=0. Then ow_mem_addr1=0x000123 next cycle with mp=1, and it holds one more cycle.
- Secondary write to 0x000010 with data 0xABCDEF in an idle cycle. Expect ready at t, and we[s]=1 with wdata 0xABCDEF at t+1; ready is not asserted at t+1.
- Secondary read with memory returning 0x5A5A5A. Expect rvalid=1 and rdata=0x5A5A5A exactly at t+3, for one cycle.
- Starvation with STARVE_MAX=8: iw_pl_req held and iw_dma_valid rising at t0. No ready during t0..t7; at t8 ow_pl_stall=1 and ow_dma_ready=1; r_wait=0 at t9.
- Reset asserted in ACC of a read: no rvalid afterwards, state IDLE, and no write enable pulse.
